// File: rtl/sine_dds_scheduler_if.sv
// Control and sample bundle for the two-channel sine DDS scheduler.
// The master side (control registers) drives enables, tuning words and pulses;
// the slave side (the scheduler) returns samples, strobes and the slot owner.
interface sine_dds_scheduler_if #(
  parameter int unsigned PHASE_W = 16
);

  logic               en_ch0;
  logic               en_ch1;
  logic [PHASE_W-1:0] ftw_ch0;
  logic [PHASE_W-1:0] ftw_ch1;
  logic               ftw_load_ch0;
  logic               ftw_load_ch1;
  logic               phase_clr_ch0;
  logic               phase_clr_ch1;
  logic [7:0]         sample_ch0;
  logic [7:0]         sample_ch1;
  logic               valid_ch0;
  logic               valid_ch1;
  logic               slot;

  modport master (
    output en_ch0, en_ch1, ftw_ch0, ftw_ch1, ftw_load_ch0, ftw_load_ch1,
           phase_clr_ch0, phase_clr_ch1,
    input  sample_ch0, sample_ch1, valid_ch0, valid_ch1, slot
  );

  modport slave (
    input  en_ch0, en_ch1, ftw_ch0, ftw_ch1, ftw_load_ch0, ftw_load_ch1,
           phase_clr_ch0, phase_clr_ch1,
    output sample_ch0, sample_ch1, valid_ch0, valid_ch1, slot
  );

endinterface

// File: rtl/sine_dds_scheduler.sv
// Two-channel DDS sine generator sharing one quarter-wave table.
// A toggling slot bit grants the table to ch0 / ch1 on alternate clocks; the
// owning channel's phase is folded into a table address plus sign, and the
// signed sample is registered at the end of that slot cycle.
module sine_dds_scheduler #(
  parameter int unsigned PHASE_W = 16
) (
  input logic                clk,
  input logic                reset,
  sine_dds_scheduler_if.slave bus
);

  // Quarter-wave entry: floor(127 * sin(pi/2 * a / 255)), evaluated at
  // elaboration with a Q28 fixed-point Taylor series. The small bias keeps
  // exact-integer points (a = 255) from truncating one step low.
  function automatic logic [6:0] sin_val(input int unsigned a);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint v;
    x    = (longint'(421657428) * longint'(a)) / 255;  // pi/2 * a/255 in Q28
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int k = 1; k <= 6; k++) begin
      term = -((term * x2) >>> 28) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    v = (sum * 127 + 1024) >>> 28;
    if (v > 127) v = 127;
    if (v < 0) v = 0;
    return v[6:0];
  endfunction

  // sin_fragment: combinational quarter-wave table, monotonic 0..127.
  logic [6:0] rom [256];
  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [6:0] Val = sin_val(g);
    assign rom[g] = Val;
  end

  logic [PHASE_W-1:0] phase_ch0_q, phase_ch1_q;
  logic [PHASE_W-1:0] ftw_reg_ch0_q, ftw_reg_ch1_q;
  logic               slot_q;
  logic [7:0]         sample_ch0_q, sample_ch1_q;
  logic               valid_ch0_q, valid_ch1_q;

  logic [9:0] top_bits;  // {q, idx} of the slot owner's phase
  logic [1:0] quad;
  logic [7:0] idx;
  logic [7:0] addr;
  logic [7:0] mag;
  logic [7:0] folded;

  // Quadrant fold of the owning channel's phase into a signed sample.
  always_comb begin
    top_bits = slot_q ? phase_ch1_q[PHASE_W-1:PHASE_W-10]
                      : phase_ch0_q[PHASE_W-1:PHASE_W-10];
    quad     = top_bits[9:8];
    idx      = top_bits[7:0];
    addr     = quad[0] ? ~idx : idx;
    mag      = {1'b0, rom[addr]};
    folded   = quad[1] ? (~mag) + 8'd1 : mag;
  end

  // Slot toggle, per-channel phase advance, tuning-word capture and sample registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_ch0_q   <= '0;
      phase_ch1_q   <= '0;
      ftw_reg_ch0_q <= '0;
      ftw_reg_ch1_q <= '0;
      slot_q        <= 1'b0;
      sample_ch0_q  <= 8'h00;
      sample_ch1_q  <= 8'h00;
      valid_ch0_q   <= 1'b0;
      valid_ch1_q   <= 1'b0;
    end else begin
      slot_q      <= ~slot_q;
      valid_ch0_q <= 1'b0;
      valid_ch1_q <= 1'b0;

      // Advance uses the pre-load tuning word; a new word applies from the next slot.
      if (bus.ftw_load_ch0) ftw_reg_ch0_q <= bus.ftw_ch0;
      if (bus.ftw_load_ch1) ftw_reg_ch1_q <= bus.ftw_ch1;

      if (!slot_q && bus.en_ch0) begin
        sample_ch0_q <= folded;
        valid_ch0_q  <= 1'b1;
        phase_ch0_q  <= phase_ch0_q + ftw_reg_ch0_q;
      end
      if (slot_q && bus.en_ch1) begin
        sample_ch1_q <= folded;
        valid_ch1_q  <= 1'b1;
        phase_ch1_q  <= phase_ch1_q + ftw_reg_ch1_q;
      end

      // Clear overrides advance; the sample from the old phase is still emitted.
      if (bus.phase_clr_ch0) phase_ch0_q <= '0;
      if (bus.phase_clr_ch1) phase_ch1_q <= '0;
    end
  end

  assign bus.sample_ch0 = sample_ch0_q;
  assign bus.sample_ch1 = sample_ch1_q;
  assign bus.valid_ch0  = valid_ch0_q;
  assign bus.valid_ch1  = valid_ch1_q;
  assign bus.slot       = slot_q;

endmodule
